// File: rtl/addcmp_pkg.sv
// Shared operand width and type for the add-compare scheduler.
package addcmp_pkg;

  localparam int unsigned OPW = 50;

  typedef logic [OPW-1:0] operand_t;

endpackage

// File: rtl/AddCmp50.sv
// 50-bit adder-comparator: eq is set when (a + b) mod 2^50 equals c.
module AddCmp50
  import addcmp_pkg::*;
(
  input  operand_t i_a,
  input  operand_t i_b,
  input  operand_t i_c,
  output logic     o_eq
);

  operand_t w_sum;

  // Sum is truncated to the operand width, so carry-out is dropped on purpose.
  always_comb begin
    w_sum = i_a + i_b;
    o_eq  = (w_sum == i_c);
  end

endmodule

// File: rtl/addcmp_rr_arb.sv
// Combinational round-robin arbiter: first valid request at or after ptr wins.
module addcmp_rr_arb #(
  parameter int unsigned NREQ = 4,
  localparam int unsigned IDW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  gnt_id,
  output logic            any
);

  // Scan ptr, ptr+1, ... wrapping modulo NREQ; the first hit is granted.
  always_comb begin
    int unsigned idx;
    gnt    = '0;
    gnt_id = '0;
    any    = 1'b0;
    idx    = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = (32'(ptr) + k) % NREQ;
      if (!any && req[IDW'(idx)]) begin
        any              = 1'b1;
        gnt[IDW'(idx)]   = 1'b1;
        gnt_id           = IDW'(idx);
      end
    end
  end

endmodule

// File: rtl/addcmp_sched.sv
// Round-robin scheduler sharing one AddCmp50 among NREQ requesters,
// two-stage pipeline with response backpressure and saturating statistics.
module addcmp_sched
  import addcmp_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned CNTW = 16,
  localparam int unsigned IDW = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*OPW-1:0] req_a,
  input  logic [NREQ*OPW-1:0] req_b,
  input  logic [NREQ*OPW-1:0] req_c,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic              rsp_eq,
  input  logic              clr_cnt,
  output logic [CNTW-1:0]   op_cnt,
  output logic [CNTW-1:0]   match_cnt
);

  localparam logic [CNTW-1:0] CNT_MAX = '1;

  // S1 operand stage
  operand_t         r_a1, r_b1, r_c1;
  logic [IDW-1:0]   r_id1;
  logic             r_v1;
  // S2 result stage
  logic             r_eq2;
  logic [IDW-1:0]   r_id2;
  logic             r_v2;
  // Arbitration and statistics
  logic [IDW-1:0]   r_ptr;
  logic [CNTW-1:0]  r_op_cnt;
  logic [CNTW-1:0]  r_match_cnt;

  logic [NREQ-1:0]  w_gnt;
  logic [IDW-1:0]   w_gnt_id;
  logic             w_any;
  logic             w_s2_free;
  logic             w_s1_free;
  logic             w_accept;
  logic             w_rsp_fire;
  logic             w_eq;
  logic [IDW-1:0]   w_ptr_nxt;
  operand_t         w_a [NREQ];
  operand_t         w_b [NREQ];
  operand_t         w_c [NREQ];

  // Split the packed operand buses into per-requester slices.
  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign w_a[i] = req_a[i*OPW +: OPW];
    assign w_b[i] = req_b[i*OPW +: OPW];
    assign w_c[i] = req_c[i*OPW +: OPW];
  end

  addcmp_rr_arb #(.NREQ(NREQ)) u_arb (
    .req    (req_valid),
    .ptr    (r_ptr),
    .gnt    (w_gnt),
    .gnt_id (w_gnt_id),
    .any    (w_any)
  );

  AddCmp50 u_addcmp (
    .i_a  (r_a1),
    .i_b  (r_b1),
    .i_c  (r_c1),
    .o_eq (w_eq)
  );

  // Stall chain, grant qualification and pointer successor.
  always_comb begin
    w_s2_free  = !r_v2 || rsp_ready;
    w_s1_free  = !r_v1 || w_s2_free;
    w_accept   = w_any && w_s1_free;
    w_rsp_fire = r_v2 && rsp_ready;
    req_ready  = w_gnt & {NREQ{w_s1_free}};
    w_ptr_nxt  = (w_gnt_id == IDW'(NREQ - 1)) ? '0 : w_gnt_id + IDW'(1);
  end

  // Pipeline stages: S1 captures operands on accept, S2 captures the compare result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a1  <= '0;
      r_b1  <= '0;
      r_c1  <= '0;
      r_id1 <= '0;
      r_v1  <= 1'b0;
      r_eq2 <= 1'b0;
      r_id2 <= '0;
      r_v2  <= 1'b0;
    end else begin
      if (w_s1_free) begin
        r_v1 <= w_accept;
        if (w_accept) begin
          r_a1  <= w_a[w_gnt_id];
          r_b1  <= w_b[w_gnt_id];
          r_c1  <= w_c[w_gnt_id];
          r_id1 <= w_gnt_id;
        end
      end
      if (w_s2_free) begin
        r_v2  <= r_v1;
        r_eq2 <= w_eq;
        r_id2 <= r_id1;
      end
    end
  end

  // Round-robin pointer advances past the granted requester only on accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (w_accept) begin
      r_ptr <= w_ptr_nxt;
    end
  end

  // Saturating operation/match counters; clear takes priority over increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op_cnt    <= '0;
      r_match_cnt <= '0;
    end else if (clr_cnt) begin
      r_op_cnt    <= '0;
      r_match_cnt <= '0;
    end else if (w_rsp_fire) begin
      if (r_op_cnt != CNT_MAX) begin
        r_op_cnt <= r_op_cnt + CNTW'(1);
      end
      if (r_eq2 && (r_match_cnt != CNT_MAX)) begin
        r_match_cnt <= r_match_cnt + CNTW'(1);
      end
    end
  end

  assign rsp_valid = r_v2;
  assign rsp_id    = r_id2;
  assign rsp_eq    = r_eq2;
  assign op_cnt    = r_op_cnt;
  assign match_cnt = r_match_cnt;

endmodule

// File: tb/tb_addcmp_sched.sv
// Directed, table-driven bench for addcmp_sched (NREQ=4, CNTW=4).
module tb_addcmp_sched;

  localparam int unsigned NREQ = 4;
  localparam int unsigned CNTW = 4;
  localparam int unsigned OPW  = 50;
  localparam int unsigned IDW  = 2;
  localparam int unsigned NVEC = 7;

  typedef struct {
    int          id;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] c;
    logic        eq;
  } vec_t;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*OPW-1:0]  req_a, req_b, req_c;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [IDW-1:0]       rsp_id;
  logic                 rsp_eq;
  logic                 clr_cnt;
  logic [CNTW-1:0]      op_cnt;
  logic [CNTW-1:0]      match_cnt;

  int checks   = 0;
  int failures = 0;

  addcmp_sched #(.NREQ(NREQ), .CNTW(CNTW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_c     (req_c),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_eq    (rsp_eq),
    .clr_cnt   (clr_cnt),
    .op_cnt    (op_cnt),
    .match_cnt (match_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input int id, input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] c);
    req_a[id*OPW +: OPW] = OPW'(a);
    req_b[id*OPW +: OPW] = OPW'(b);
    req_c[id*OPW +: OPW] = OPW'(c);
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b1;
    clr_cnt   = 1'b0;
    req_a     = '0;
    req_b     = '0;
    req_c     = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  vec_t vt [NVEC];
  int   exp_op;
  int   exp_match;
  int   acc;
  int   hs;

  initial begin
    vt[0] = '{2, 64'd5, 64'd7, 64'd12, 1'b1};
    vt[1] = '{0, 64'h0003_FFFF_FFFF_FFFF, 64'd1, 64'd0, 1'b1};
    vt[2] = '{1, 64'h0003_FFFF_FFFF_FFFF, 64'd1, 64'h0004_0000_0000_0000, 1'b1};
    vt[3] = '{3, 64'd100, 64'd200, 64'd301, 1'b0};
    vt[4] = '{1, 64'h0003_FFFF_FFFF_FFFF, 64'h0003_FFFF_FFFF_FFFF, 64'h0003_FFFF_FFFF_FFFE, 1'b1};
    vt[5] = '{0, 64'd0, 64'd0, 64'd0, 1'b1};
    vt[6] = '{2, 64'd1, 64'd0, 64'd0, 1'b0};

    // Reset values
    rst_n = 1'b0; req_valid = '0; rsp_ready = 1'b1; clr_cnt = 1'b0;
    req_a = '0; req_b = '0; req_c = '0;
    @(negedge clk);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_id",    64'(rsp_id),    64'd0);
    check("rst_rsp_eq",    64'(rsp_eq),    64'd0);
    check("rst_op_cnt",    64'(op_cnt),    64'd0);
    check("rst_match_cnt", 64'(match_cnt), 64'd0);
    check("rst_req_ready", 64'(req_ready), 64'd0);
    do_reset();

    // Table: one isolated request per vector, latency and eq checked
    exp_op = 0; exp_match = 0;
    for (int i = 0; i < int'(NVEC); i++) begin
      req_a = '0; req_b = '0; req_c = '0;
      set_ops(vt[i].id, vt[i].a, vt[i].b, vt[i].c);
      req_valid = NREQ'(1) << vt[i].id;
      @(negedge clk);
      check($sformatf("tbl%0d_ready", i), 64'(req_ready), 64'(1) << vt[i].id);
      step();
      req_valid = '0;
      @(negedge clk);
      check($sformatf("tbl%0d_early", i), 64'(rsp_valid), 64'd0);
      step();
      @(negedge clk);
      check($sformatf("tbl%0d_valid", i), 64'(rsp_valid), 64'd1);
      check($sformatf("tbl%0d_id", i),    64'(rsp_id),    64'(vt[i].id));
      check($sformatf("tbl%0d_eq", i),    64'(rsp_eq),    64'(vt[i].eq));
      exp_op++;
      if (vt[i].eq) exp_match++;
      step();
      @(negedge clk);
      check($sformatf("tbl%0d_op", i),    64'(op_cnt),    64'(exp_op));
      check($sformatf("tbl%0d_match", i), 64'(match_cnt), 64'(exp_match));
      check($sformatf("tbl%0d_idle", i),  64'(rsp_valid), 64'd0);
      step();
    end

    // Round-robin with all four held, mismatching operands
    do_reset();
    for (int i = 0; i < int'(NREQ); i++) set_ops(i, 64'(10*i + 1), 64'd3, 64'(10*i + 5));
    req_valid = '1;
    for (int n = 0; n < 7; n++) begin
      @(negedge clk);
      if (n < 5) check($sformatf("rr%0d_ready", n), 64'(req_ready), 64'(1) << (n % 4));
      if (n >= 2) begin
        check($sformatf("rr%0d_valid", n), 64'(rsp_valid), 64'd1);
        check($sformatf("rr%0d_id", n),    64'(rsp_id),    64'((n - 2) % 4));
        check($sformatf("rr%0d_eq", n),    64'(rsp_eq),    64'd0);
      end else begin
        check($sformatf("rr%0d_valid", n), 64'(rsp_valid), 64'd0);
      end
      step();
      if (n == 4) req_valid = '0;
    end
    @(negedge clk);
    check("rr_op",    64'(op_cnt),    64'd5);
    check("rr_match", 64'(match_cnt), 64'd0);
    step();

    // Backpressure: two in flight, then req_ready drops and outputs hold
    do_reset();
    rsp_ready = 1'b0;
    set_ops(0, 64'd5, 64'd5, 64'd10);
    set_ops(1, 64'd5, 64'd5, 64'd11);
    set_ops(2, 64'd1, 64'd1, 64'd2);
    set_ops(3, 64'd1, 64'd1, 64'd2);
    req_valid = '1;
    acc = 0;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      check($sformatf("bp%0d_ready", n), 64'(req_ready), (n == 0) ? 64'd1 : (n == 1) ? 64'd2 : 64'd0);
      if (req_ready != '0) acc++;
      if (n >= 2) begin
        check($sformatf("bp%0d_valid", n), 64'(rsp_valid), 64'd1);
        check($sformatf("bp%0d_id", n),    64'(rsp_id),    64'd0);
        check($sformatf("bp%0d_eq", n),    64'(rsp_eq),    64'd1);
      end
      step();
    end
    check("bp_accepts", 64'(acc), 64'd2);
    req_valid = '0;
    rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_drain0_valid", 64'(rsp_valid), 64'd1);
    check("bp_drain0_id",    64'(rsp_id),    64'd0);
    check("bp_drain0_eq",    64'(rsp_eq),    64'd1);
    step();
    @(negedge clk);
    check("bp_drain1_valid", 64'(rsp_valid), 64'd1);
    check("bp_drain1_id",    64'(rsp_id),    64'd1);
    check("bp_drain1_eq",    64'(rsp_eq),    64'd0);
    step();
    @(negedge clk);
    check("bp_empty", 64'(rsp_valid), 64'd0);
    check("bp_op",    64'(op_cnt),    64'd2);
    check("bp_match", 64'(match_cnt), 64'd1);
    step();

    // Saturation: 20 matching responses into 4-bit counters
    do_reset();
    set_ops(0, 64'd1, 64'd1, 64'd2);
    req_valid = 4'b0001;
    acc = 0; hs = 0;
    for (int n = 0; n < 60 && hs < 20; n++) begin
      @(negedge clk);
      if (rsp_valid && rsp_ready) hs++;
      if (req_ready[0]) acc++;
      step();
      if (acc >= 20) req_valid = '0;
    end
    @(negedge clk);
    check("sat_handshakes", 64'(hs),        64'd20);
    check("sat_accepts",    64'(acc),       64'd20);
    check("sat_op",         64'(op_cnt),    64'd15);
    check("sat_match",      64'(match_cnt), 64'd15);
    check("sat_idle",       64'(rsp_valid), 64'd0);
    step();

    // Clear in the same cycle as a response handshake
    set_ops(0, 64'd3, 64'd4, 64'd7);
    req_valid = 4'b0001;
    @(negedge clk);
    check("clr_ready", 64'(req_ready), 64'd1);
    step();
    req_valid = '0;
    @(negedge clk);
    step();
    clr_cnt = 1'b1;
    @(negedge clk);
    check("clr_rsp_valid", 64'(rsp_valid), 64'd1);
    step();
    clr_cnt = 1'b0;
    @(negedge clk);
    check("clr_op",    64'(op_cnt),    64'd0);
    check("clr_match", 64'(match_cnt), 64'd0);
    step();

    // Reset with both stages full, then lowest valid index wins first
    rsp_ready = 1'b0;
    req_valid = '1;
    @(negedge clk);
    step();
    @(negedge clk);
    step();
    @(negedge clk);
    check("mf_pre_valid", 64'(rsp_valid), 64'd1);
    check("mf_pre_ready", 64'(req_ready), 64'd0);
    #1;
    rst_n = 1'b0;
    req_valid = '0;
    #1;
    check("mf_rst_valid", 64'(rsp_valid), 64'd0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    req_valid = 4'b1010;
    #1;
    check("mf_first_grant", 64'(req_ready), 64'd2);
    check("mf_no_rsp",      64'(rsp_valid), 64'd0);
    step();
    @(negedge clk);
    check("mf_second_grant", 64'(req_ready), 64'd8);
    check("mf_no_rsp2",      64'(rsp_valid), 64'd0);
    step();
    req_valid = '0;
    @(negedge clk);
    check("mf_rsp_valid", 64'(rsp_valid), 64'd1);
    check("mf_rsp_id",    64'(rsp_id),    64'd1);
    step();
    @(negedge clk);
    check("mf_rsp2_id", 64'(rsp_id), 64'd3);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
